// File: rtl/alu_bcd_scan_pkg.sv
// Shared definitions for the ALU / BCD display block: operation codes,
// FSM state encoding, special segment patterns and the digit decoder.
package alu_bcd_pkg;

    typedef enum logic [1:0] {
        MODE_ADD = 2'd0,
        MODE_SUB = 2'd1,
        MODE_MAX = 2'd2,
        MODE_AND = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Segment order gfedcba, active-low.
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Decimal digit to segment pattern; non-decimal nibbles show blank.
    function automatic logic [6:0] seg7_digit(input logic [3:0] nib);
        case (nib)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/alu_bcd_scan_if.sv
// Operand/request/result/display bundle between a requester and alu_bcd_scan.
interface alu_bcd_scan_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 4
);
    logic [WIDTH-1:0]  left;
    logic [WIDTH-1:0]  right;
    logic [1:0]        mode;
    logic              start;
    logic              busy;
    logic              done;
    logic [WIDTH:0]    result;
    logic              neg;
    logic [6:0]        seg;
    logic [DIGITS-1:0] an;
    logic              dp;

    modport master (
        output left, right, mode, start,
        input  busy, done, result, neg, seg, an, dp
    );

    modport slave (
        input  left, right, mode, start,
        output busy, done, result, neg, seg, an, dp
    );
endinterface

// File: rtl/alu_bcd_scan_seg7.sv
// bcd_seg7_scan: time-multiplexed 7-segment driver for a packed BCD value.
// A prescaler advances the active digit every REFRESH_DIV clocks.
// Build option ALU_BCD_LZB_EN: blank leading-zero digits above the most
// significant nonzero digit (digit 0 and the minus sign are always shown).
module bcd_seg7_scan
    import alu_bcd_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [4*DIGITS-1:0]   bcd,
    input  logic                  neg,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  dp
);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(DIGITS);

    logic [PW-1:0] pre_q;
    logic [IW-1:0] idx_q;
    logic [3:0]    nib;
    logic          blank;
`ifdef ALU_BCD_LZB_EN
    int            msd;
`endif

    // Prescaler and digit index, both cleared by clr.
    always_ff @(posedge clk) begin
        if (clr) begin
            pre_q <= '0;
            idx_q <= '0;
        end else if (pre_q == PW'(REFRESH_DIV - 1)) begin
            pre_q <= '0;
            idx_q <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end else begin
            pre_q <= pre_q + PW'(1);
        end
    end

    // Digit select, leading-zero blanking and segment decode for the active digit.
    always_comb begin
        nib   = bcd[4*idx_q +: 4];
        an    = ~(DIGITS'(1) << idx_q);
        blank = 1'b0;
`ifdef ALU_BCD_LZB_EN
        msd = 0;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd[4*d +: 4] != 4'd0) msd = d;
        end
        blank = (int'(idx_q) > msd);
`endif
        if (neg && (idx_q == IW'(DIGITS - 1))) seg = SEG_MINUS;
        else if (blank)                         seg = SEG_BLANK;
        else                                    seg = seg7_digit(nib);
    end

    assign dp = 1'b1;

endmodule

// File: rtl/alu_bcd_scan.sv
// alu_bcd_scan: captures two operands on a start request, computes
// add/sub/max/and at WIDTH+1 bits, converts the magnitude to BCD with a
// bit-serial double-dabble and shows it on a multiplexed 7-segment display.
// Build option ALU_BCD_LZB_EN enables leading-zero blanking in the display.
module alu_bcd_scan
    import alu_bcd_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic          clk,
    input  logic          clr,
    alu_bcd_scan_if.slave bus
);
    localparam int RW = WIDTH + 1;          // ALU result width
    localparam int BW = 4 * DIGITS;         // BCD field width
    localparam int CW = $clog2(RW + 1);     // shift counter width

    if (!(10 ** (DIGITS - 1) > 2 ** (WIDTH + 1) - 1)) begin : g_digits_check
        $error("alu_bcd_scan: DIGITS too small to display a WIDTH+1 bit magnitude");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] left_q, right_q;
    mode_e            mode_q;
    logic [RW-1:0]    alu_mag, mag_q, result_q;
    logic             alu_neg, sign_q, neg_q;
    logic [BW+RW-1:0] work_q, dd_adj, dd_next;
    logic [CW-1:0]    cnt_q;
    logic [BW-1:0]    disp_q;
    logic             done_q;

    // ALU on the captured operands.
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        alu_mag = '0;
        alu_neg = 1'b0;
        unique case (mode_q)
            MODE_ADD: alu_mag = {1'b0, left_q} + {1'b0, right_q};
            MODE_SUB: begin
                alu_neg = (left_q < right_q);
                alu_mag = alu_neg ? {1'b0, right_q - left_q} : {1'b0, left_q - right_q};
            end
            MODE_MAX: alu_mag = (left_q >= right_q) ? {1'b0, left_q} : {1'b0, right_q};
            MODE_AND: alu_mag = {1'b0, left_q & right_q};
            default:  alu_mag = '0;
        endcase
    end

    // One double-dabble step: add 3 to each BCD nibble >= 5, then shift left.
    always_comb begin
        dd_adj = work_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (work_q[RW+4*d +: 4] >= 4'd5) dd_adj[RW+4*d +: 4] = work_q[RW+4*d +: 4] + 4'd3;
        end
        dd_next = dd_adj << 1;
    end

    // FSM next state: one LOAD cycle, WIDTH+1 shifts, one DONE cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (bus.start) state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_SHIFT;
            ST_SHIFT: if (cnt_q == CW'(RW)) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (clr) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Operand capture, conversion datapath and result/display registers.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (clr) begin
            left_q   <= '0;
            right_q  <= '0;
            mode_q   <= MODE_ADD;
            mag_q    <= '0;
            sign_q   <= 1'b0;
            work_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            neg_q    <= 1'b0;
            disp_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= (state_q == ST_DONE);
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        left_q  <= bus.left;
                        right_q <= bus.right;
                        mode_q  <= mode_e'(bus.mode);
                    end
                end
                ST_LOAD: begin
                    mag_q  <= alu_mag;
                    sign_q <= alu_neg;
                    work_q <= {{BW{1'b0}}, alu_mag};
                    cnt_q  <= '0;
                end
                ST_SHIFT: begin
                    if (cnt_q != CW'(RW)) begin
                        work_q <= dd_next;
                        cnt_q  <= cnt_q + CW'(1);
                    end else begin
                        // Entry to DONE: publish the finished conversion.
                        result_q <= mag_q;
                        neg_q    <= sign_q;
                        disp_q   <= work_q[RW +: BW];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = (state_q != ST_IDLE);
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.neg    = neg_q;

    bcd_seg7_scan #(
        .DIGITS      (DIGITS),
        .REFRESH_DIV (REFRESH_DIV)
    ) u_scan (
        .clk (clk),
        .clr (clr),
        .bcd (disp_q),
        .neg (neg_q),
        .seg (bus.seg),
        .an  (bus.an),
        .dp  (bus.dp)
    );

endmodule

// File: tb/tb_alu_bcd_scan.sv
// Self-checking bench for alu_bcd_scan (WIDTH=8, DIGITS=4, REFRESH_DIV=4).
// Expected values come from integer arithmetic on the operands and
// decimal digit extraction by division.
module tb_alu_bcd_scan;
    localparam int WIDTH       = 8;
    localparam int DIGITS      = 4;
    localparam int REFRESH_DIV = 4;
    localparam int DONE_LAT    = WIDTH + 4;

    logic clk = 1'b0;
    logic clr = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [6:0] seg_code [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                  7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    localparam logic [6:0] MINUS_CODE = 7'b0111111;
    localparam logic [6:0] BLANK_CODE = 7'b1111111;

    alu_bcd_scan_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus();

    alu_bcd_scan #(
        .WIDTH       (WIDTH),
        .DIGITS      (DIGITS),
        .REFRESH_DIV (REFRESH_DIV)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic int pow10(input int e);
        int p = 1;
        for (int i = 0; i < e; i++) p = p * 10;
        return p;
    endfunction

    function automatic void model(input int l, input int r, input int m, output int mag, output int sg);
        sg = 0;
        case (m)
            0: mag = l + r;
            1: begin mag = (l >= r) ? l - r : r - l; sg = (l < r) ? 1 : 0; end
            2: mag = (l > r) ? l : r;
            default: mag = l & r;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int v, input int n, input int i);
        if (n != 0 && i == DIGITS - 1) return MINUS_CODE;
`ifdef ALU_BCD_LZB_EN
        if (i > 0 && v < pow10(i)) return BLANK_CODE;
`endif
        return seg_code[(v / pow10(i)) % 10];
    endfunction

    task automatic check_display(input int v, input int n, input string name);
        int idx, hot;
        for (int k = 0; k < DIGITS * REFRESH_DIV; k++) begin
            @(posedge clk); #1;
            idx = 0; hot = 0;
            for (int i = 0; i < DIGITS; i++) if (bus.an[i] == 1'b0) begin hot++; idx = i; end
            checks++;
            if (hot != 1) begin
                errors++; $display("FAIL %s an_onehot got=%b", name, bus.an);
            end else begin
                checks++;
                if (bus.seg !== exp_seg(v, n, idx)) begin
                    errors++; $display("FAIL %s seg digit%0d got=%b want=%b", name, idx, bus.seg, exp_seg(v, n, idx));
                end
            end
            checks++;
            if (bus.dp !== 1'b1) begin errors++; $display("FAIL %s dp got=%b want=1", name, bus.dp); end
        end
    endtask

    task automatic test_reset();
        clr = 1'b1; bus.start = 1'b1; bus.left = 8'd9; bus.right = 8'd3; bus.mode = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0)    begin errors++; $display("FAIL reset busy got=%b want=0", bus.busy); end
        checks++; if (bus.done !== 1'b0)    begin errors++; $display("FAIL reset done got=%b want=0", bus.done); end
        checks++; if (bus.result !== 9'd0)  begin errors++; $display("FAIL reset result got=%0d want=0", bus.result); end
        checks++; if (bus.neg !== 1'b0)     begin errors++; $display("FAIL reset neg got=%b want=0", bus.neg); end
        checks++; if (bus.an !== 4'b1110)   begin errors++; $display("FAIL reset an got=%b want=1110", bus.an); end
        clr = 1'b0; bus.start = 1'b0;
        check_display(0, 0, "reset_disp");
    endtask

    // Issue one operation, scramble the inputs while busy, check latency and results.
    task automatic run_op(input int l, input int r, input int m, input string name);
        int mag, sg, done_at, ndone;
        model(l, r, m, mag, sg);
        @(posedge clk); #1;
        bus.left = 8'(l); bus.right = 8'(r); bus.mode = 2'(m); bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        done_at = -1; ndone = 0;
        for (int c = 1; c <= DONE_LAT + 4; c++) begin
            bus.left = 8'($urandom_range(0, 255)); bus.right = 8'($urandom_range(0, 255));
            bus.mode = 2'($urandom_range(0, 3));
            @(posedge clk); #1;
            if (c == 1) begin
                checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL %s busy got=%b want=1", name, bus.busy); end
            end
            if (bus.done === 1'b1) begin ndone++; if (done_at < 0) done_at = c; end
        end
        checks++; if (done_at != DONE_LAT) begin errors++; $display("FAIL %s done_cycle got=%0d want=%0d", name, done_at, DONE_LAT); end
        checks++; if (ndone != 1)          begin errors++; $display("FAIL %s done_pulses got=%0d want=1", name, ndone); end
        checks++; if (bus.result !== 9'(mag)) begin errors++; $display("FAIL %s result got=%0d want=%0d", name, bus.result, mag); end
        checks++; if (bus.neg !== 1'(sg))  begin errors++; $display("FAIL %s neg got=%b want=%0d", name, bus.neg, sg); end
        check_display(mag, sg, name);
    endtask

    task automatic test_directed();
        run_op(200, 55, 0, "add_200_55");
        run_op(10, 20, 1, "sub_10_20");
        run_op(7, 200, 2, "max_7_200");
        run_op(8'hF0, 8'h3C, 3, "and_f0_3c");
        run_op(255, 255, 0, "add_255_255");
        run_op(20, 20, 1, "sub_equal");
        run_op(0, 0, 0, "add_zero");
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++)
            run_op($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 3), "random");
    endtask

    task automatic test_start_while_busy();
        int done_at, ndone;
        @(posedge clk); #1;
        bus.left = 8'd100; bus.right = 8'd33; bus.mode = 2'd0; bus.start = 1'b1;
        @(posedge clk); #1;
        done_at = -1; ndone = 0;
        for (int c = 1; c <= 40; c++) begin
            bus.start = (c == 3 || c == 7);
            bus.left = 8'd1; bus.right = 8'd2; bus.mode = 2'd3;
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin ndone++; if (done_at < 0) done_at = c; end
        end
        bus.start = 1'b0;
        checks++; if (ndone != 1)          begin errors++; $display("FAIL busy_start done_pulses got=%0d want=1", ndone); end
        checks++; if (done_at != DONE_LAT) begin errors++; $display("FAIL busy_start done_cycle got=%0d want=%0d", done_at, DONE_LAT); end
        checks++; if (bus.result !== 9'd133) begin errors++; $display("FAIL busy_start result got=%0d want=133", bus.result); end
        checks++; if (bus.busy !== 1'b0)   begin errors++; $display("FAIL busy_start busy got=%b want=0", bus.busy); end
    endtask

    task automatic test_clr_abort();
        int ndone;
        @(posedge clk); #1;
        bus.left = 8'd250; bus.right = 8'd3; bus.mode = 2'd1; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; ndone = 0;
        for (int c = 1; c <= 30; c++) begin
            clr = (c == 6);
            @(posedge clk); #1;
            if (bus.done === 1'b1) ndone++;
            if (c == 6) begin
                checks++; if (bus.busy !== 1'b0)   begin errors++; $display("FAIL clr_abort busy got=%b want=0", bus.busy); end
                checks++; if (bus.an !== 4'b1110)  begin errors++; $display("FAIL clr_abort an got=%b want=1110", bus.an); end
                checks++; if (bus.result !== 9'd0) begin errors++; $display("FAIL clr_abort result got=%0d want=0", bus.result); end
                checks++; if (bus.neg !== 1'b0)    begin errors++; $display("FAIL clr_abort neg got=%b want=0", bus.neg); end
            end
        end
        clr = 1'b0;
        checks++; if (ndone != 0) begin errors++; $display("FAIL clr_abort done_pulses got=%0d want=0", ndone); end
        check_display(0, 0, "clr_abort_disp");
    endtask

    task automatic test_scan();
        logic [3:0] want;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        for (int k = 0; k < (DIGITS + 1) * REFRESH_DIV; k++) begin
            want = ~(4'b0001 << ((k / REFRESH_DIV) % DIGITS));
            checks++;
            if (bus.an !== want) begin errors++; $display("FAIL scan an sample%0d got=%b want=%b", k, bus.an, want); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        bus.left = '0; bus.right = '0; bus.mode = '0; bus.start = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_start_while_busy();
        test_clr_abort();
        test_scan();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
